// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - differential PWM frame receiver recovering samples, tone period and silence
//
// Purpose: locks to the PWM frame on pwm_pos/pwm_neg, counts high slots per line
// per frame, publishes one signed sample per frame, measures the frame distance
// between positive zero crossings, flags silence and reports alignment loss.
//
// Ports:
//   clk            in   1     system clock
//   reset          in   1     synchronous active-high reset
//   pwm_pos        in   1     positive-half PWM line (asynchronous to slot phase)
//   pwm_neg        in   1     negative-half PWM line
//   sample_pos     out  N+1   high-slot count of pwm_pos in last frame
//   sample_neg     out  N+1   high-slot count of pwm_neg in last frame
//   sample         out  N+2   signed sample_pos - sample_neg
//   sample_valid   out  1     pulse: sample_* updated
//   period_frames  out  P     frames between last two positive zero crossings
//   period_valid   out  1     pulse: period_frames updated
//   silent         out  1     level: SILENT_FRAMES or more consecutive zero frames
//   sync_err       out  1     pulse: misaligned edge, lock dropped
module pwm_capture #(
  parameter int N             = 8,
  parameter int TICK_DIV      = 125,
  parameter int SILENT_FRAMES = 16,
  parameter int P             = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_pos,
  input  logic                pwm_neg,
  output logic [N:0]          sample_pos,
  output logic [N:0]          sample_neg,
  output logic signed [N+1:0] sample,
  output logic                sample_valid,
  output logic [P-1:0]        period_frames,
  output logic                period_valid,
  output logic                silent,
  output logic                sync_err
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ZC_W  = $clog2(SILENT_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_MID   = DIV_W'(TICK_DIV / 2);
  localparam logic [N-1:0]     SLOT_LAST = '1;
  localparam logic [P-1:0]     PER_MAX   = '1;
  localparam logic [ZC_W-1:0]  ZC_MAX    = ZC_W'(SILENT_FRAMES);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t               state_q, state_d;
  logic [2:0]           pos_sync_q, neg_sync_q;
  logic                 pos_rise_q, neg_rise_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [N-1:0]         slot_q, slot_d;
  logic [N:0]           cnt_pos_q, cnt_pos_d, cnt_neg_q, cnt_neg_d;
  logic [N:0]           sample_pos_q, sample_pos_d, sample_neg_q, sample_neg_d;
  logic signed [N+1:0]  sample_q, sample_d, prev_q, prev_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 period_valid_q, period_valid_d;
  logic                 sync_err_q, sync_err_d;
  logic                 silent_q, silent_d;
  logic [P-1:0]         period_q, period_d, per_cnt_q, per_cnt_d;
  logic [ZC_W-1:0]      zero_cnt_q, zero_cnt_d;

  logic                 any_rise, edge_ok, sample_pt, frame_end, crossing, zero_frame;
  logic [N:0]           pos_total, neg_total;
  logic signed [N+1:0]  frame_sample;

  // Stage 3 of the synchronizer is the level that lines up with the registered
  // rise pulse, so counting and edge detection see the same slot phase.
  assign any_rise  = pos_rise_q | neg_rise_q;
  assign sample_pt = (div_q == DIV_MID);
  assign frame_end = (div_q == DIV_LAST) && (slot_q == SLOT_LAST);
  // Edges are tolerated in a window straddling the frame boundary.
  assign edge_ok   = ((slot_q == '0) && (div_q < DIV_MID)) ||
                     ((slot_q == SLOT_LAST) && (div_q > DIV_MID));

  // Totals include this cycle's sample point so a frame end never loses a count.
  assign pos_total    = cnt_pos_q + {{N{1'b0}}, sample_pt & pos_sync_q[2]};
  assign neg_total    = cnt_neg_q + {{N{1'b0}}, sample_pt & neg_sync_q[2]};
  assign frame_sample = $signed({1'b0, pos_total}) - $signed({1'b0, neg_total});
  assign crossing     = (prev_q[N+1] || (prev_q == '0)) &&
                        !frame_sample[N+1] && (frame_sample != '0);
  assign zero_frame   = (pos_total == '0) && (neg_total == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= HUNT;
      pos_sync_q     <= '0;
      neg_sync_q     <= '0;
      pos_rise_q     <= 1'b0;
      neg_rise_q     <= 1'b0;
      div_q          <= '0;
      slot_q         <= '0;
      cnt_pos_q      <= '0;
      cnt_neg_q      <= '0;
      sample_pos_q   <= '0;
      sample_neg_q   <= '0;
      sample_q       <= '0;
      prev_q         <= '0;
      sample_valid_q <= 1'b0;
      period_valid_q <= 1'b0;
      sync_err_q     <= 1'b0;
      silent_q       <= 1'b0;
      period_q       <= '0;
      per_cnt_q      <= '0;
      zero_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      pos_sync_q     <= {pos_sync_q[1:0], pwm_pos};
      neg_sync_q     <= {neg_sync_q[1:0], pwm_neg};
      pos_rise_q     <= pos_sync_q[1] & ~pos_sync_q[2];
      neg_rise_q     <= neg_sync_q[1] & ~neg_sync_q[2];
      div_q          <= div_d;
      slot_q         <= slot_d;
      cnt_pos_q      <= cnt_pos_d;
      cnt_neg_q      <= cnt_neg_d;
      sample_pos_q   <= sample_pos_d;
      sample_neg_q   <= sample_neg_d;
      sample_q       <= sample_d;
      prev_q         <= prev_d;
      sample_valid_q <= sample_valid_d;
      period_valid_q <= period_valid_d;
      sync_err_q     <= sync_err_d;
      silent_q       <= silent_d;
      period_q       <= period_d;
      per_cnt_q      <= per_cnt_d;
      zero_cnt_q     <= zero_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    slot_d         = slot_q;
    cnt_pos_d      = cnt_pos_q;
    cnt_neg_d      = cnt_neg_q;
    sample_pos_d   = sample_pos_q;
    sample_neg_d   = sample_neg_q;
    sample_d       = sample_q;
    prev_d         = prev_q;
    sample_valid_d = 1'b0;
    period_valid_d = 1'b0;
    sync_err_d     = 1'b0;
    silent_d       = silent_q;
    period_d       = period_q;
    per_cnt_d      = per_cnt_q;
    zero_cnt_d     = zero_cnt_q;

    unique case (state_q)
      HUNT: begin
        div_d     = '0;
        slot_d    = '0;
        cnt_pos_d = '0;
        cnt_neg_d = '0;
        if (any_rise) begin
          // The edge cycle itself is div 0 of slot 0.
          state_d = LOCK;
          div_d   = DIV_W'(1);
        end
      end
      LOCK: begin
        if (any_rise && !edge_ok) begin
          // Partial frame is dropped; silence and period history survive.
          sync_err_d = 1'b1;
          state_d    = HUNT;
          div_d      = '0;
          slot_d     = '0;
          cnt_pos_d  = '0;
          cnt_neg_d  = '0;
        end else begin
          cnt_pos_d = pos_total;
          cnt_neg_d = neg_total;
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            slot_d = slot_q + 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
          if (frame_end) begin
            cnt_pos_d      = '0;
            cnt_neg_d      = '0;
            sample_pos_d   = pos_total;
            sample_neg_d   = neg_total;
            sample_d       = frame_sample;
            sample_valid_d = 1'b1;
            prev_d         = frame_sample;
            if (crossing) begin
              // A zero or saturated count means the interval is unknown.
              if ((per_cnt_q != '0) && (per_cnt_q != PER_MAX)) begin
                period_d       = per_cnt_q;
                period_valid_d = 1'b1;
              end
              per_cnt_d = P'(1);
            end else if (per_cnt_q != PER_MAX) begin
              per_cnt_d = per_cnt_q + 1'b1;
            end
            if (zero_frame) begin
              if (zero_cnt_q != ZC_MAX) zero_cnt_d = zero_cnt_q + 1'b1;
            end else begin
              zero_cnt_d = '0;
            end
            silent_d = (zero_cnt_d == ZC_MAX);
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign sample_pos    = sample_pos_q;
  assign sample_neg    = sample_neg_q;
  assign sample        = sample_q;
  assign sample_valid  = sample_valid_q;
  assign period_frames = period_q;
  assign period_valid  = period_valid_q;
  assign silent        = silent_q;
  assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - frame-level bench for pwm_capture
module tb_pwm_capture;

  localparam int N  = 4;
  localparam int TD = 8;
  localparam int SF = 4;
  localparam int P  = 8;
  localparam int FRAME_CLK = TD * (2 ** N);

  logic                clk = 1'b0;
  logic                reset;
  logic                pwm_pos;
  logic                pwm_neg;
  logic [N:0]          sample_pos;
  logic [N:0]          sample_neg;
  logic signed [N+1:0] sample;
  logic                sample_valid;
  logic [P-1:0]        period_frames;
  logic                period_valid;
  logic                silent;
  logic                sync_err;

  always #5 clk = ~clk;

  pwm_capture #(.N(N), .TICK_DIV(TD), .SILENT_FRAMES(SF), .P(P)) dut (
    .clk           (clk),
    .reset         (reset),
    .pwm_pos       (pwm_pos),
    .pwm_neg       (pwm_neg),
    .sample_pos    (sample_pos),
    .sample_neg    (sample_neg),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .period_frames (period_frames),
    .period_valid  (period_valid),
    .silent        (silent),
    .sync_err      (sync_err)
  );

  typedef struct {
    int pos_k; int neg_k;
    int e_pos; int e_neg; int e_samp; bit e_pv; int e_per; bit e_sil;
  } vec_t;

  typedef struct {
    int spos; int sneg; int ssamp; bit pv; int per; bit sil; bit gap_chk;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[20];
  int   tests    = 0;
  int   fails    = 0;
  int   sync_cnt = 0;
  int   stray_pv = 0;
  int   cyc      = 0;
  int   last_sv  = 0;
  bit   locked   = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sample_pos"},    int'(sample_pos), 0);
    check({tag, "_sample_neg"},    int'(sample_neg), 0);
    check({tag, "_sample"},        int'(sample), 0);
    check({tag, "_sample_valid"},  int'(sample_valid), 0);
    check({tag, "_period_frames"}, int'(period_frames), 0);
    check({tag, "_period_valid"},  int'(period_valid), 0);
    check({tag, "_silent"},        int'(silent), 0);
    check({tag, "_sync_err"},      int'(sync_err), 0);
  endtask

  task automatic drive_slot(input bit p, input bit n);
    repeat (TD) begin
      @(negedge clk);
      pwm_pos = p;
      pwm_neg = n;
    end
  endtask

  // Frame-aligned stimulus: each line is high for the first k slots.
  task automatic frame(input int pk, input int nk, input int ep, input int en,
                       input int es, input bit pv, input int per, input bit sil);
    exp_t e;
    if (locked || pk > 0 || nk > 0) begin
      e = '{ep, en, es, pv, per, sil, locked};
      sb.push_back(e);
      locked = 1'b1;
    end
    for (int s = 0; s < 2 ** N; s++) drive_slot(s < pk, s < nk);
  endtask

  initial begin
    vecs = '{
      '{5, 0, 5, 0, 5, 0, 0, 0},
      '{5, 0, 5, 0, 5, 0, 0, 0},
      '{0, 16, 0, 16, -16, 0, 0, 0},
      '{16, 16, 16, 16, 0, 0, 0, 0},
      '{3, 0, 3, 0, 3, 1, 4, 0},
      '{3, 0, 3, 0, 3, 0, 0, 0},
      '{3, 0, 3, 0, 3, 0, 0, 0},
      '{3, 0, 3, 0, 3, 0, 0, 0},
      '{0, 3, 0, 3, -3, 0, 0, 0},
      '{0, 3, 0, 3, -3, 0, 0, 0},
      '{0, 3, 0, 3, -3, 0, 0, 0},
      '{0, 3, 0, 3, -3, 0, 0, 0},
      '{3, 0, 3, 0, 3, 1, 8, 0},
      '{0, 3, 0, 3, -3, 0, 0, 0},
      '{0, 0, 0, 0, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0, 0, 0, 1},
      '{0, 0, 0, 0, 0, 0, 0, 1},
      '{1, 0, 1, 0, 1, 1, 7, 0}
    };
    reset   = 1'b1;
    pwm_pos = 1'b0;
    pwm_neg = 1'b0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          cyc++;
          if (sync_err) sync_cnt++;
          if (period_valid && !sample_valid) stray_pv++;
          if (sample_valid) begin
            if (sb.size() == 0) begin
              check("unexpected_sample_valid", 1, 0);
            end else begin
              e = sb.pop_front();
              check("sample_pos",   int'(sample_pos), e.spos);
              check("sample_neg",   int'(sample_neg), e.sneg);
              check("sample",       int'(sample), e.ssamp);
              check("period_valid", int'(period_valid), int'(e.pv));
              if (e.pv) check("period_frames", int'(period_frames), e.per);
              check("silent",       int'(silent), int'(e.sil));
              if (e.gap_chk) check("frame_gap", cyc - last_sv, FRAME_CLK);
            end
            last_sv = cyc;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check_idle("por");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 20; i++)
      frame(vecs[i].pos_k, vecs[i].neg_k, vecs[i].e_pos, vecs[i].e_neg,
            vecs[i].e_samp, vecs[i].e_pv, vecs[i].e_per, vecs[i].e_sil);
    check("sync_err_during_table", sync_cnt, 0);

    // Misaligned edge at slot 7: lock drops, the frame is discarded.
    for (int s = 0; s < 2 ** N; s++) drive_slot(s == 7, 1'b0);
    locked = 1'b0;
    check("sync_err_after_slot7", sync_cnt, 1);
    // Re-lock keeps period history: previous sample +1, counter at 1.
    frame(2, 0, 2, 0, 2, 0, 0, 0);
    frame(0, 2, 0, 2, -2, 0, 0, 0);
    frame(2, 0, 2, 0, 2, 1, 3, 0);

    // Reset in the middle of a frame.
    for (int s = 0; s < 9; s++) drive_slot(s < 4, 1'b0);
    @(negedge clk);
    reset   = 1'b1;
    pwm_pos = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    reset  = 1'b0;
    locked = 1'b0;
    repeat (16) @(negedge clk);
    // Period counter was cleared, so the first crossing yields no period.
    frame(6, 0, 6, 0, 6, 0, 0, 0);
    frame(0, 6, 0, 6, -6, 0, 0, 0);
    frame(6, 0, 6, 0, 6, 1, 2, 0);

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("sync_err_total", sync_cnt, 1);
    check("stray_period_valid", stray_pv, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
